// File: rtl/router_fsm_np_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : router_pkg
//  Description : Shared types and helpers for the parametrised router control
//                FSM: the 4-bit state enumeration and the header address width
//                helper used to size the address field and latched port.
//  Revision    : 1.0 - initial release
// ============================================================================
package router_pkg;

   // The state values are fixed so that any unused 4-bit code is an illegal
   // encoding that the next-state logic sends back to DA.
   typedef enum logic [3:0] {
      DA   = 4'd0,   // decode address
      LFD  = 4'd1,   // load first data (header byte)
      LD   = 4'd2,   // load data
      FFS  = 4'd3,   // FIFO full state
      LAF  = 4'd4,   // load after full
      LP   = 4'd5,   // load parity
      CPE  = 4'd6,   // check parity error
      WTE  = 4'd7,   // wait till empty
      DROP = 4'd8    // discard packet addressed to a nonexistent port
   } state_e;

   // Header address width: clog2(n) but never less than one bit.
   function automatic int addr_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage : router_pkg
`default_nettype wire

// File: rtl/router_fsm_np_if.sv
`default_nettype none
// ============================================================================
//  Module      : router_fsm_np_if
//  Description : Bundle of the control/status signals between the router FSM
//                and its neighbours (source, register/parity block,
//                synchroniser and FIFO bank).
//  Ports       : master - environment side (drives the FSM inputs)
//                slave  - FSM side (drives strobes, busy, write enable,
//                         sel_port, pkt_dropped)
//  Revision    : 1.0 - initial release
// ============================================================================
interface router_fsm_np_if
   import router_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = addr_w(NUM_PORTS)
);

   // Inputs to the FSM
   logic                  pkt_valid;
   logic                  parity_done;
   logic                  low_pkt_valid;
   logic [ADDR_W-1:0]     data_in;
   logic [NUM_PORTS-1:0]  fifo_full;
   logic [NUM_PORTS-1:0]  fifo_empty;
   logic [NUM_PORTS-1:0]  soft_reset;

   // Outputs from the FSM
   logic                  busy;
   logic                  detect_add;
   logic                  lfd_state;
   logic                  ld_state;
   logic                  laf_state;
   logic                  full_state;
   logic                  rst_int_reg;
   logic                  write_enb_reg;
   logic [ADDR_W-1:0]     sel_port;
   logic                  pkt_dropped;

   modport master (
      output pkt_valid, parity_done, low_pkt_valid, data_in,
             fifo_full, fifo_empty, soft_reset,
      input  busy, detect_add, lfd_state, ld_state, laf_state, full_state,
             rst_int_reg, write_enb_reg, sel_port, pkt_dropped
   );

   modport slave (
      input  pkt_valid, parity_done, low_pkt_valid, data_in,
             fifo_full, fifo_empty, soft_reset,
      output busy, detect_add, lfd_state, ld_state, laf_state, full_state,
             rst_int_reg, write_enb_reg, sel_port, pkt_dropped
   );

endinterface : router_fsm_np_if
`default_nettype wire

// File: rtl/router_fsm_np.sv
`default_nettype none
// ============================================================================
//  Module      : router_fsm_np
//  Description : Router control FSM for NUM_PORTS destination FIFOs. Decodes
//                the header address, latches the destination, sequences the
//                load strobes / FIFO write enable / busy back-pressure, and
//                drops packets addressed to a nonexistent port.
//  Ports       : clk  - system clock, rising edge
//                rstn - asynchronous active-low reset
//                bus  - router_fsm_np_if.slave (all control/status signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module router_fsm_np
   import router_pkg::*;
#(
   parameter int NUM_PORTS = 3,
   parameter int ADDR_W    = addr_w(NUM_PORTS)
) (
   input  wire logic          clk,
   input  wire logic          rstn,
   router_fsm_np_if.slave     bus
);

   // Per-port vectors are zero-extended to the full address range so that
   // any ADDR_W-bit index is in range; nonexistent ports read as 0.
   localparam int               PAD_W      = 1 << ADDR_W;
   localparam logic [ADDR_W:0]  PORT_LIMIT = (ADDR_W+1)'(NUM_PORTS);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   sel_port_q;
   logic                pkt_dropped_q;

   logic [PAD_W-1:0]    w_full_pad, w_empty_pad, w_srst_pad;
   logic                w_addr_valid;
   logic                w_hdr_empty;
   logic                w_sel_full;
   logic                w_sel_empty;
   logic                w_sel_srst;

   logic                w_busy, w_detect_add, w_lfd, w_ld, w_laf, w_full;
   logic                w_rst_int, w_write_enb;

   assign w_full_pad   = PAD_W'(bus.fifo_full);
   assign w_empty_pad  = PAD_W'(bus.fifo_empty);
   assign w_srst_pad   = PAD_W'(bus.soft_reset);

   assign w_addr_valid = ({1'b0, bus.data_in} < PORT_LIMIT);
   assign w_hdr_empty  = w_empty_pad[bus.data_in];
   assign w_sel_full   = w_full_pad[sel_port_q];
   assign w_sel_empty  = w_empty_pad[sel_port_q];
   // A dropped packet may leave sel_port at a nonexistent port; the padded
   // vector makes its soft reset read as 0 there.
   assign w_sel_srst   = w_srst_pad[sel_port_q];

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= DA;
      end else begin
         state_q <= state_d;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      if (state_q != DA && w_sel_srst) begin
         // Timeout on the selected FIFO aborts the packet from any state.
         state_d = DA;
      end else begin
         case (state_q)
            DA: begin
               if (bus.pkt_valid) begin
                  if (!w_addr_valid)    state_d = DROP;
                  else if (w_hdr_empty) state_d = LFD;
                  else                  state_d = WTE;
               end
            end
            LFD:     state_d = LD;
            LD: begin
               if (w_sel_full)          state_d = FFS;
               else if (!bus.pkt_valid) state_d = LP;
            end
            FFS: begin
               if (!w_sel_full)         state_d = LAF;
            end
            LAF: begin
               if (bus.parity_done)        state_d = DA;
               else if (bus.low_pkt_valid) state_d = LP;
               else                        state_d = LD;
            end
            LP:      state_d = CPE;
            CPE:     state_d = w_sel_full ? FFS : DA;
            WTE: begin
               if (w_sel_empty)         state_d = LFD;
            end
            DROP: begin
               if (!bus.pkt_valid)      state_d = DA;
            end
            default: state_d = DA;
         endcase
      end
   end

   // ----------------------------------------------------------- output decode
   always_comb begin
      w_busy       = 1'b0;
      w_detect_add = 1'b0;
      w_lfd        = 1'b0;
      w_ld         = 1'b0;
      w_laf        = 1'b0;
      w_full       = 1'b0;
      w_rst_int    = 1'b0;
      w_write_enb  = 1'b0;
      case (state_q)
         DA:   w_detect_add = 1'b1;
         LFD:  begin w_lfd = 1'b1;  w_busy = 1'b1; end
         LD:   begin w_ld  = 1'b1;  w_write_enb = 1'b1; end
         FFS:  begin w_full = 1'b1; w_busy = 1'b1; end
         LAF:  begin w_laf = 1'b1;  w_busy = 1'b1; w_write_enb = 1'b1; end
         LP:   begin w_busy = 1'b1; w_write_enb = 1'b1; end
         CPE:  begin w_rst_int = 1'b1; w_busy = 1'b1; end
         WTE:  w_busy = 1'b1;
         default: ;
      endcase
   end

   // ------------------------------------------------ destination / drop pulse
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sel_port_q    <= '0;
         pkt_dropped_q <= 1'b0;
      end else begin
         if (state_q == DA && bus.pkt_valid) begin
            sel_port_q <= bus.data_in;
         end
         // High only on the edge that moves the FSM into DROP.
         pkt_dropped_q <= (state_d == DROP) && (state_q != DROP);
      end
   end

   assign bus.busy          = w_busy;
   assign bus.detect_add    = w_detect_add;
   assign bus.lfd_state     = w_lfd;
   assign bus.ld_state      = w_ld;
   assign bus.laf_state     = w_laf;
   assign bus.full_state    = w_full;
   assign bus.rst_int_reg   = w_rst_int;
   assign bus.write_enb_reg = w_write_enb;
   assign bus.sel_port      = sel_port_q;
   assign bus.pkt_dropped   = pkt_dropped_q;

endmodule : router_fsm_np
`default_nettype wire

// File: tb/tb_router_fsm_np.sv
`default_nettype none
// ============================================================================
//  Module      : tb_router_fsm_np
//  Description : Self-checking bench for router_fsm_np (NUM_PORTS=3). Directed
//                packet scenarios followed by randomized traffic, every cycle
//                compared against a packet-phase reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_router_fsm_np;

   localparam int NP = 3;
   localparam int AW = 2;

   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   router_fsm_np_if #(.NUM_PORTS(NP), .ADDR_W(AW)) bus ();

   router_fsm_np #(.NUM_PORTS(NP), .ADDR_W(AW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------ reference model
   // Packet phase as seen by the outside world; outputs derived from phase.
   typedef enum int {P_IDLE, P_HDR, P_BODY, P_STALL, P_RESUME, P_PAR,
                     P_CHK, P_WAIT, P_DISCARD} phase_t;

   phase_t          m_ph;
   logic [AW-1:0]   m_sel;
   bit              m_drop;

   task automatic model_reset();
      m_ph = P_IDLE; m_sel = '0; m_drop = 1'b0;
   endtask

   task automatic model_step();
      phase_t nx;
      int     d   = int'(bus.data_in);
      int     s   = int'(m_sel);
      bit     ok  = d < NP;
      bit     srst = (s < NP) ? bus.soft_reset[s] : 1'b0;
      bit     selfull = (s < NP) ? bus.fifo_full[s] : 1'b0;
      bit     selemp  = (s < NP) ? bus.fifo_empty[s] : 1'b0;
      nx = m_ph;
      if (m_ph != P_IDLE && srst) nx = P_IDLE;
      else begin
         case (m_ph)
            P_IDLE:    if (bus.pkt_valid) nx = !ok ? P_DISCARD :
                                              (bus.fifo_empty[d] ? P_HDR : P_WAIT);
            P_HDR:     nx = P_BODY;
            P_BODY:    nx = selfull ? P_STALL : (!bus.pkt_valid ? P_PAR : P_BODY);
            P_STALL:   nx = selfull ? P_STALL : P_RESUME;
            P_RESUME:  nx = bus.parity_done ? P_IDLE : (bus.low_pkt_valid ? P_PAR : P_BODY);
            P_PAR:     nx = P_CHK;
            P_CHK:     nx = selfull ? P_STALL : P_IDLE;
            P_WAIT:    nx = selemp ? P_HDR : P_WAIT;
            P_DISCARD: nx = bus.pkt_valid ? P_DISCARD : P_IDLE;
            default:   nx = P_IDLE;
         endcase
      end
      if (m_ph == P_IDLE && bus.pkt_valid) m_sel = bus.data_in;
      m_drop = (nx == P_DISCARD) && (m_ph != P_DISCARD);
      m_ph   = nx;
   endtask

   // {busy, detect_add, lfd, ld, laf, full, rst_int, write_enb, pkt_dropped}
   function automatic logic [8:0] exp_flags();
      bit busy = m_ph inside {P_HDR, P_STALL, P_RESUME, P_PAR, P_CHK, P_WAIT};
      bit we   = m_ph inside {P_BODY, P_PAR, P_RESUME};
      return {busy, m_ph == P_IDLE, m_ph == P_HDR, m_ph == P_BODY,
              m_ph == P_RESUME, m_ph == P_STALL, m_ph == P_CHK, we, m_drop};
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_flags"},
            32'({bus.busy, bus.detect_add, bus.lfd_state, bus.ld_state,
                 bus.laf_state, bus.full_state, bus.rst_int_reg,
                 bus.write_enb_reg, bus.pkt_dropped}),
            32'(exp_flags()));
      check({tag, "_sel"}, 32'(bus.sel_port), 32'(m_sel));
   endtask

   // One clock: model advances on the same edge, outputs checked mid-cycle.
   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_outputs(tag);
   endtask

   task automatic drive(input bit pv, input logic [AW-1:0] din, input logic [NP-1:0] emp,
                        input logic [NP-1:0] full, input logic [NP-1:0] sr,
                        input bit pd, input bit lpv);
      bus.pkt_valid = pv;  bus.data_in = din;     bus.fifo_empty  = emp;
      bus.fifo_full = full; bus.soft_reset = sr;  bus.parity_done = pd;
      bus.low_pkt_valid = lpv;
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic do_reset(input string tag);
      rstn = 1'b0;
      #1;
      model_reset();
      check_outputs(tag);
      #1 rstn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      drive(0, 2'd0, 3'b111, 3'b000, 3'b000, 0, 0);
      rstn = 1'b0;
      #1;
      model_reset();
      check_outputs("reset");
      check("reset_detect", 32'(bus.detect_add), 32'd1);
      @(negedge clk);
      rstn = 1'b1;

      // Normal packet to port 1: pkt_valid 4 cycles then low.
      drive(1, 2'd1, 3'b111, 3'b000, 3'b000, 0, 0);
      tick("np_lfd");
      check("np_lfd_state", 32'(bus.lfd_state), 32'd1);
      repeat (3) tick("np_ld");
      bus.pkt_valid = 0;
      tick("np_lp");
      tick("np_cpe");
      check("np_rst_int", 32'(bus.rst_int_reg), 32'd1);
      tick("np_da");
      check("np_sel", 32'(bus.sel_port), 32'd1);

      // Busy destination: port 2 not empty -> wait, then release.
      drive(1, 2'd2, 3'b011, 3'b000, 3'b000, 0, 0);
      repeat (3) tick("bd_wte");
      check("bd_busy", 32'(bus.busy), 32'd1);
      bus.fifo_empty = 3'b111;
      tick("bd_lfd");
      bus.pkt_valid = 0;
      repeat (4) tick("bd_tail");

      // Full path with unselected / selected soft reset.
      drive(1, 2'd1, 3'b111, 3'b000, 3'b000, 0, 0);
      tick("fp_lfd"); tick("fp_ld");
      bus.fifo_full = 3'b010;
      tick("fp_ffs");
      check("fp_full_state", 32'(bus.full_state), 32'd1);
      bus.soft_reset = 3'b001;
      tick("fp_sr_other");
      drive(0, 2'd1, 3'b111, 3'b000, 3'b000, 0, 1);
      tick("fp_laf"); tick("fp_lp"); tick("fp_cpe"); tick("fp_da");

      drive(1, 2'd1, 3'b111, 3'b000, 3'b000, 0, 0);
      tick("sr_lfd"); tick("sr_ld");
      bus.fifo_full = 3'b010;
      tick("sr_ffs");
      bus.fifo_full = 3'b000; bus.soft_reset = 3'b010;
      tick("sr_da");
      check("sr_detect", 32'(bus.detect_add), 32'd1);
      bus.soft_reset = 3'b000; bus.pkt_valid = 0;
      tick("sr_idle");

      // Invalid address held three cycles.
      drive(1, 2'd3, 3'b111, 3'b000, 3'b000, 0, 0);
      tick("ia_drop");
      check("ia_pulse", 32'(bus.pkt_dropped), 32'd1);
      repeat (2) tick("ia_hold");
      check("ia_pulse_gone", 32'(bus.pkt_dropped), 32'd0);
      bus.pkt_valid = 0;
      tick("ia_da");

      // Asynchronous reset while loading data.
      drive(1, 2'd1, 3'b111, 3'b000, 3'b000, 0, 0);
      tick("rl_lfd"); tick("rl_ld");
      do_reset("rl_rst");
      check("rl_sel", 32'(bus.sel_port), 32'd0);
      bus.pkt_valid = 0;
      tick("rl_stay");

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         logic [NP-1:0] emp, full, sr;
         for (int b = 0; b < NP; b++) begin
            emp[b]  = ($urandom_range(0, 3) != 0);
            full[b] = ($urandom_range(0, 7) == 0);
            sr[b]   = ($urandom_range(0, 39) == 0);
         end
         drive($urandom_range(0, 9) < 7, AW'($urandom_range(0, 3)), emp, full, sr,
               $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0);
         tick("rnd");
         if ($urandom_range(0, 199) == 0) do_reset("rnd_rst");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_router_fsm_np
`default_nettype wire

// File: doc/router_fsm_np.md
Name: router_fsm_np

Overview:
- Parametrised successor to the 1x3 router control FSM.
- Supports NUM_PORTS destination FIFOs with per-port full/empty/soft-reset vectors and registers the selected destination.
- Drops packets addressed to a nonexistent port instead of stalling the source.
- Sits between the input register/parity block and the synchroniser/FIFO bank; drives load strobes, busy back-pressure and the FIFO write enable.

Parameters:
- NUM_PORTS, 3, number of destination ports (2..16).
- ADDR_W, $clog2(NUM_PORTS) (minimum 1), width of the header address field.

Ports:
- clk  in  1  system clock, rising-edge.
- rstn  in  1  asynchronous active-low reset.
- pkt_valid  in  1  source packet valid.
- parity_done  in  1  parity byte latched by the register block.
- low_pkt_valid  in  1  pkt_valid fell while the FSM was in FIFO_FULL.
- data_in  in  ADDR_W  header address bits, sampled in DECODE_ADDRESS.
- fifo_full  in  NUM_PORTS  per-port FIFO full.
- fifo_empty  in  NUM_PORTS  per-port FIFO empty.
- soft_reset  in  NUM_PORTS  per-port timeout reset from the synchroniser.
- busy  out  1  back-pressure to the source.
- detect_add  out  1  in DECODE_ADDRESS.
- lfd_state  out  1  in LOAD_FIRST_DATA.
- ld_state  out  1  in LOAD_DATA.
- laf_state  out  1  in LOAD_AFTER_FULL.
- full_state  out  1  in FIFO_FULL.
- rst_int_reg  out  1  in CHECK_PARITY_ERROR.
- write_enb_reg  out  1  FIFO write enable: LOAD_DATA, LOAD_PARITY or LOAD_AFTER_FULL.
- sel_port  out  ADDR_W  latched destination.
- pkt_dropped  out  1  one-cycle pulse on entering DROP.

Behaviour:
- Reset: rstn low forces state DA, sel_port=0, pkt_dropped=0 immediately (asynchronous), regardless of current state. Decoded outputs follow from state DA: detect_add=1, all other state outputs, busy and write_enb_reg =0.
- Moore outputs are decoded combinationally from the state register only.
- busy=1 in LFD, FFS, LAF, LP, CPE, WTE; busy=0 in DA, LD, DROP.
- Address valid means data_in < NUM_PORTS. In DA, if pkt_valid=1, sel_port <= data_in at the clock edge.
- Transitions, evaluated each rising edge, in priority order:
  - Soft reset first: if state != DA and soft_reset[sel_port]=1, next state is DA. soft_reset bits of unselected ports are ignored.
  - DA: pkt_valid & valid & fifo_empty[data_in] -> LFD; pkt_valid & valid & !fifo_empty[data_in] -> WTE; pkt_valid & !valid -> DROP; else stay.
  - LFD -> LD unconditionally (exactly one cycle).
  - LD: fifo_full[sel_port] -> FFS; else !pkt_valid -> LP; else stay.
  - FFS: !fifo_full[sel_port] -> LAF; else stay.
  - LAF: parity_done -> DA; else low_pkt_valid -> LP; else -> LD.
  - LP -> CPE unconditionally.
  - CPE: fifo_full[sel_port] -> FFS; else -> DA.
  - WTE: fifo_empty[sel_port] -> LFD; else stay.
  - DROP: stay while pkt_valid=1; -> DA on the first cycle pkt_valid=0.
- pkt_dropped is registered: high for exactly the first cycle in DROP.
- write_enb_reg is never high in DROP.
- sel_port holds its value outside DA.
- Illegal or unused state encodings recover to DA on the next edge.
- Latency: first data is written the cycle after LFD. Header-to-DA minimum for a 1-byte payload is 5 cycles: DA, LFD, LD, LP, CPE.

Decomposition:
- Shared package router_pkg holds:
  - state enum: DA, LFD, LD, FFS, LAF, LP, CPE, WTE, DROP (4-bit);
  - function addr_w(n) returning max(1, clog2(n)).
- No sub-module: a single state register, a next-state block, an output decode and the sel_port/pkt_dropped registers.

Test Plan:
- Reset: rstn=0 while the FSM is in LD -> same delta: detect_add=1, ld_state=0, busy=0, sel_port=0; rstn=1 -> remains in DA.
- Normal packet: NUM_PORTS=3, data_in=2'b01, fifo_empty=3'b111, pkt_valid high for 4 cycles then low -> DA,LFD,LD,LD,LD,LP,CPE,DA. lfd_state and rst_int_reg each high one cycle; sel_port=1; write_enb_reg high in LD/LP.
- Busy destination: data_in=2'b10, fifo_empty[2]=0 -> WTE with busy=1 held; assert fifo_empty[2]=1 -> LFD next cycle.
- Full path: in LD, fifo_full[1]=1 -> full_state=1, busy=1; drop fifo_full, low_pkt_valid=1, parity_done=0 -> LAF then LP then CPE.
- Invalid address: data_in=2'b11 with pkt_valid held 3 cycles -> DROP, pkt_dropped pulse 1 cycle, busy=0, write_enb_reg=0 throughout; back to DA one cycle after pkt_valid=0.
- Soft reset: in FFS with sel_port=1, soft_reset=3'b001 -> no change; soft_reset=3'b010 -> DA next edge; soft_reset asserted in the same cycle as fifo_full deasserting -> DA, not LAF.
